// File: rtl/soi_pkg.sv
// Shared types, default widths and helpers for the SoI sample scheduler.
package soi_pkg;

  localparam int DEF_N_SRC  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TS_W   = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_SRC_W  = $clog2(DEF_N_SRC);

  // Record handed to the DPI bridge, at the default widths.
  typedef struct packed {
    logic [DEF_SRC_W-1:0]  src;
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_DATA_W-1:0] data;
  } soi_rec_t;

  // Output register state: EMPTY has no record, HOLD presents one.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

  // a + b clamped to max_v; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/soi_sample_sched_if.sv
// Record channel from the scheduler to the DPI bridge.
//
// Handshake: a record transfers on every rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// master keeps out_src/out_ts/out_data stable. out_valid never depends
// combinationally on out_ready. out_* carry no meaning while out_valid is low.
interface soi_sample_sched_if
  import soi_pkg::*;
#(
  parameter int SRC_W  = DEF_SRC_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              out_valid;
  logic              out_ready;
  logic [SRC_W-1:0]  out_src;
  logic [TS_W-1:0]   out_ts;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_src, output out_ts,
                  output out_data, input out_ready);
  modport slave  (input out_valid, input out_src, input out_ts,
                  input out_data, output out_ready);
endinterface

// File: rtl/soi_rr_arb.sv
// Combinational round-robin picker: first requester at or above rr_ptr, with wrap.
module soi_rr_arb
  import soi_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [SRC_W-1:0] grant_idx
);

  // Scan N_SRC positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int         pos;
    logic [SRC_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    idx         = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_SRC) pos = pos - N_SRC;
      idx = SRC_W'(pos);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/soi_sample_sched.sv
// Shares one DPI observation channel among N_SRC SoI sources: one holding
// slot per source, timestamping, round-robin arbitration and a one-record
// output register with a valid/ready handshake.
module soi_sample_sched
  import soi_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SRC_W  = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_en,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  soi_sample_sched_if.master      out_if,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy,
  output out_state_e              dbg_state
);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } slot_t;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } rec_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            slot_q [N_SRC];
  slot_t            slot_d [N_SRC];
  logic [N_SRC-1:0] full_q, full_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  out_state_e       state_q, state_d;
  rec_t             out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;
  logic             handshake;
  logic             grant_en;
  logic             grant;
  logic [N_SRC-1:0] cap;
  logic [N_SRC-1:0] freed;
  logic [SRC_W:0]   n_drop;

  soi_rr_arb #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_arb (
    .req         (full_q),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Output FSM next state, output-register load and round-robin pointer advance.
  always_comb begin
    handshake = (state_q == OUT_HOLD) && out_if.out_ready;
    grant_en  = (state_q == OUT_EMPTY) || handshake;
    grant     = grant_en && grant_valid;
    state_d   = state_q;
    out_d     = out_q;
    rr_d      = rr_q;
    if (grant) begin
      state_d    = OUT_HOLD;
      out_d.src  = grant_idx;
      out_d.ts   = slot_q[grant_idx].ts;
      out_d.data = slot_q[grant_idx].data;
      rr_d       = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
    end else if (handshake) begin
      state_d = OUT_EMPTY;
    end
  end

  // Slot capture/release and drop counting; a slot granted this cycle may refill at once.
  always_comb begin
    full_d = full_q;
    slot_d = slot_q;
    n_drop = '0;
    freed  = '0;
    cap    = src_en & src_valid;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant && (grant_idx == SRC_W'(i))) begin
        freed[i]  = 1'b1;
        full_d[i] = 1'b0;
      end
      if (cap[i]) begin
        if (!full_q[i] || freed[i]) begin
          full_d[i]      = 1'b1;
          slot_d[i].ts   = ts_q;
          slot_d[i].data = src_data[i*DATA_W +: DATA_W];
        end else begin
          n_drop = n_drop + (SRC_W+1)'(1);
        end
      end
    end
    drop_d = CNT_W'(sat_add(32'(drop_q), 32'(n_drop), 32'(CNT_MAX)));
    ts_d   = ts_q + TS_W'(1);
  end

  // Control state with synchronous reset; reset drops every pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      out_q   <= '0;
      full_q  <= '0;
      rr_q    <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      full_q  <= full_d;
      rr_q    <= rr_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
    end
  end

  // Slot payload needs no reset: it is only read while its full bit is set.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign out_if.out_valid = (state_q == OUT_HOLD);
  assign out_if.out_src   = out_q.src;
  assign out_if.out_ts    = out_q.ts;
  assign out_if.out_data  = out_q.data;
  assign drop_cnt         = drop_q;
  assign busy             = (|full_q) || (state_q == OUT_HOLD);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_soi_sample_sched.sv
// Directed bench for soi_sample_sched with a cycle-level behavioural model.
module tb_soi_sample_sched;
  import soi_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 32;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int CMAX = 15;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src_en = '1;
  logic [N-1:0]  src_valid = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [CW-1:0] drop_cnt;
  logic          busy;
  out_state_e    dbg_state;
  bit            chk_on = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  soi_sample_sched_if #(.SRC_W(SW), .TS_W(TW), .DATA_W(DW)) bus ();

  soi_sample_sched #(
    .N_SRC (N), .DATA_W (DW), .TS_W (TW), .CNT_W (CW), .SRC_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_en    (src_en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .out_if    (bus),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each source owns a one-deep box; the output holds at most one record.
  bit              m_full [N];
  logic [TW-1:0]   m_sts  [N];
  logic [DW-1:0]   m_sdat [N];
  int              m_ptr;
  bit              m_ov;
  int              m_osrc;
  logic [TW-1:0]   m_ots;
  logic [DW-1:0]   m_odat;
  int              m_drop;
  logic [TW-1:0]   m_ts;

  always @(posedge clk) begin : model
    bit hs;
    bit gnt;
    int g;
    int drops;
    bit was_full [N];
    if (rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0; m_ov = 1'b0; m_osrc = 0; m_ots = '0; m_odat = '0;
      m_drop = 0; m_ts = '0;
    end else begin
      was_full = m_full;
      hs  = m_ov && bus.out_ready;
      gnt = 1'b0;
      g   = 0;
      if (!m_ov || hs) begin
        for (int k = 0; k < N; k++) begin
          if (!gnt && m_full[(m_ptr + k) % N]) begin
            gnt = 1'b1;
            g   = (m_ptr + k) % N;
          end
        end
      end
      if (gnt) begin
        m_ov = 1'b1; m_osrc = g; m_ots = m_sts[g]; m_odat = m_sdat[g];
        m_full[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end else if (hs) begin
        m_ov = 1'b0;
      end
      drops = 0;
      for (int i = 0; i < N; i++) begin
        if (src_en[i] && src_valid[i]) begin
          if (!was_full[i] || (gnt && g == i)) begin
            m_full[i] = 1'b1;
            m_sts[i]  = m_ts;
            m_sdat[i] = src_data[i*DW +: DW];
          end else begin
            drops++;
          end
        end
      end
      m_drop = (m_drop + drops > CMAX) ? CMAX : m_drop + drops;
      m_ts   = m_ts + 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_ov;
    for (int i = 0; i < N; i++) b = b | m_full[i];
    return b;
  endfunction

  // Every cycle: compare all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_valid", bus.out_valid, m_ov);
      check("m_busy", busy, model_busy());
      check("m_drop", drop_cnt, m_drop);
      check("m_state", dbg_state, m_ov);
      if (m_ov) begin
        check("m_src", bus.out_src, m_osrc);
        check("m_ts", bus.out_ts, m_ts_out());
        check("m_data", bus.out_data, m_odat);
      end
    end
  end

  function automatic logic [TW-1:0] m_ts_out();
    return m_ots;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Leaves the bench in the first post-reset cycle (ts = 0).
  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    src_en = '1;
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    src_data[i*DW +: DW] = w;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.out_ready = 1'b1;

    // Single sample from source 2 at ts=10.
    do_reset();
    at_neg();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("model_ts0", m_ts, 0);
    step();
    repeat (9) step();
    check("model_ts10", m_ts, 10);
    src_valid = 4'b0100;
    set_word(2, 32'hA5A5_0001);
    step();
    src_valid = '0;
    at_neg();
    check("single_busy_t11", busy, 1);
    check("single_valid_t11", bus.out_valid, 0);
    step();
    at_neg();
    check("single_valid", bus.out_valid, 1);
    check("single_src", bus.out_src, 2);
    check("single_ts", bus.out_ts, 10);
    check("single_data", bus.out_data, 32'hA5A5_0001);
    step();
    at_neg();
    check("single_done_valid", bus.out_valid, 0);
    check("single_done_busy", busy, 0);

    // Fairness: all sources strobe every cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 32'h0F00_0000 + i);
    src_valid = '1;
    step();
    step();
    for (int k = 0; k < 12; k++) begin
      at_neg();
      check("rr_valid", bus.out_valid, 1);
      check("rr_src", bus.out_src, k % N);
      step();
    end
    src_valid = '0;
    repeat (6) step();

    // Backpressure with drops on source 1.
    do_reset();
    step();
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      src_valid = 4'b0010;
      set_word(1, 32'h0000_1000 + k);
      at_neg();
      if (k >= 2) begin
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_ts", bus.out_ts, 2);
        check("bp_hold_data", bus.out_data, 32'h0000_1000);
      end
      step();
    end
    src_valid = '0;
    bus.out_ready = 1'b1;
    at_neg();
    check("bp_drop", drop_cnt, 6);
    check("bp_first_ts", bus.out_ts, 2);
    step();
    at_neg();
    check("bp_second_valid", bus.out_valid, 1);
    check("bp_second_ts", bus.out_ts, 3);
    check("bp_second_data", bus.out_data, 32'h0000_1001);
    step();
    at_neg();
    check("bp_drained", bus.out_valid, 0);
    step();

    // Refill on grant for source 0.
    do_reset();
    src_valid = 4'b0001;
    set_word(0, 32'h0000_00D0);
    step();
    set_word(0, 32'h0000_00D1);
    step();
    src_valid = '0;
    at_neg();
    check("refill_ts_a", bus.out_ts, 0);
    check("refill_data_a", bus.out_data, 32'h0000_00D0);
    step();
    at_neg();
    check("refill_valid_b", bus.out_valid, 1);
    check("refill_src_b", bus.out_src, 0);
    check("refill_ts_b", bus.out_ts, 1);
    check("refill_data_b", bus.out_data, 32'h0000_00D1);
    check("refill_drop", drop_cnt, 0);
    repeat (3) step();

    // Capture mask then drop-counter saturation.
    do_reset();
    src_en = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      src_valid = 4'b1000;
      at_neg();
      check("mask_busy", busy, 0);
      check("mask_drop", drop_cnt, 0);
      step();
    end
    src_valid = '0;
    src_en = '1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 23; k++) begin
      src_valid = 4'b0001;
      set_word(0, 32'h0000_5000 + k);
      at_neg();
      if (k == 10) check("sat_mid", drop_cnt, 8);
      step();
    end
    src_valid = '0;
    at_neg();
    check("sat_full", drop_cnt, 15);
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Reset in the middle of traffic.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 32'h0000_7700 + i);
    src_valid = '1;
    step();
    step();
    src_valid = '0;
    at_neg();
    check("mid_valid", bus.out_valid, 1);
    check("mid_busy", busy, 1);
    check("mid_drop", drop_cnt, 3);
    rst = 1'b1;
    step();
    at_neg();
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_src", bus.out_src, 0);
    check("rst_mid_ts", bus.out_ts, 0);
    check("rst_mid_data", bus.out_data, 0);
    check("rst_mid_drop", drop_cnt, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("post_rst_valid", bus.out_valid, 0);
      check("post_rst_busy", busy, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
